e_scale_dbuf_loader: RTL and testbench
======================================

// Module: e_scale_dbuf_loader
// PURPOSE
//  Double-buffered E-scale register file (tail + rank) for the conv-core requant stage. Streams
//  512b scale words through valid/ready into a shadow bank while the active bank feeds the output
//  stage; a swap makes the next tile's scales live with no load stall. Channel count and widths
//  are parametrised.
// PARAMETERS
//  SA_ROW_NUM  4    SA rows in conv core (output channel groups)
//  ROW_NUM     16   rows per SA; entries N = SA_ROW_NUM*ROW_NUM
//  PAR_W       2    scales per entry (pe_parallel_weight_18)
//  TAIL_W      16   tail scalar width; TSET_W = TAIL_W*PAR_W
//  RANK_W      8    rank scalar width; RSET_W = RANK_W*PAR_W
//  WORD_W      512  stream word width
// PORTS
//  clk              in   1                   clock
//  reset            in   1                   synchronous, active-high
//  load_start       in   1                   pulse: begin loading shadow bank
//  load_mode        in   1                   0: one scalar/entry (zero-ext); 1: PAR_W packed
//  tail_valid/ready in/out 1                 tail stream handshake
//  tail_word        in   WORD_W              tail data
//  rank_valid/ready in/out 1                 rank stream handshake
//  rank_word        in   WORD_W              rank data
//  shadow_full      out  1                   shadow bank complete, awaiting swap
//  swap             in   1                   request shadow->active exchange
//  swap_ack         out  1                   1-cycle pulse: swap performed
//  rd_idx           in   $clog2(ROW_NUM+1)   output row index, 1..ROW_NUM; 0 = none
//  tail_sets        out  SA_ROW_NUM*TSET_W   active tail sets, channel c at [c*TSET_W+:TSET_W]
//  rank_sets        out  SA_ROW_NUM*RSET_W   active rank sets, same packing
// BEHAVIOUR
//  - Reset: both banks 0, active_sel=0, FSM IDLE, readys 0, shadow_full 0, swap_ack 0, sets 0.
//  - FSM IDLE->LOAD on load_start (load_mode latched, tail_ptr=rank_ptr=0); load_start ignored
//    outside IDLE. LOAD->FULL the cycle after both ptrs reach N. FULL->IDLE on swap.
//  - Entries/word: mode0 tail WORD_W/TAIL_W, rank WORD_W/RANK_W; mode1 WORD_W/TSET_W, /RSET_W.
//    Default: tail 2 words (m0) / 4 (m1); rank 1 (m0) / 2 (m1).
//  - tail_ready=1 iff LOAD and tail_ptr<N (same for rank); streams independent, any order/gaps.
//    Handshake writes shadow entries ptr..ptr+EPW-1 (clipped at N-1), ptr+=EPW (saturates at N).
//    Lane k -> entry ptr+k; mode0 upper (PAR_W-1) scalars of each set = 0.
//  - shadow_full=1 exactly in FULL. swap in FULL: active_sel flips at edge, swap_ack=1 next cycle.
//    swap in IDLE/LOAD ignored, no ack.
//  - Read: rd_idx registered, 1-cycle latency; channel c = active[c*ROW_NUM+rd_idx-1].
//    rd_idx=0 or >ROW_NUM -> zero. Read sampled on swap edge uses pre-swap bank; next reads new.
//  - Shadow writes never alter active bank or sets. Reset mid-load aborts, clears both banks.
// STRUCTURE
//  - Shared pkg/include: SA_ROW_NUM, ROW_NUM, PAR_W, TAIL_W, RANK_W, WORD_W, derived N/set widths,
//    MODE_SCALAR=0 / MODE_PACKED=1, FSM state encodings.
//  - Sub-module e_scale_bank (params SCAL_W, PAR_W, N, WORD_W): two-bank array, stream write port
//    with ptr, registered read port; instantiated for tail and rank. Top: FSM, active_sel, swap.
// TESTING
//  1 Reset held 3 cycles -> all outputs 0, readys 0, shadow_full 0; rd_idx=1 -> sets 0.
//  2 Mode0: tail words lane value=word*32+lane+1, rank lane=lane+1; swap; rd_idx=1 ->
//    tail_sets={32'h31,32'h21,32'h11,32'h01}, rank_sets={16'h31,16'h21,16'h11,16'h01}.
//  3 Mode1, valid toggling 1010..: ready falls after 4th tail / 2nd rank handshake; shadow_full
//    rises next cycle after the later; extra valids not accepted.
//  4 Load bank B while reading A idx 1..16 every cycle -> outputs stay A; idx 0 and 17 -> zero.
//  5 swap during LOAD -> no ack, sets unchanged; swap in FULL with rd_idx=2 same cycle ->
//    that read returns old data, next read new, swap_ack one cycle.
//  6 reset after 1 tail word of load -> IDLE, banks 0; fresh load_start completes normally.

Source files
------------

// File: rtl/e_scale_dbuf_loader_pkg.sv
// Shared constants and types for the double-buffered E-scale loader.
//   SA_ROW_NUM/ROW_NUM/PAR_W/TAIL_W/RANK_W/WORD_W : geometry of the scale register file
//   N, TSET_W, RSET_W, RIDX_W                     : derived entry count, set widths, read index width
//   MODE_SCALAR/MODE_PACKED                       : load_mode encodings
//   state_e                                       : loader FSM states
package e_scale_dbuf_loader_pkg;

    localparam int unsigned SA_ROW_NUM = 4;
    localparam int unsigned ROW_NUM    = 16;
    localparam int unsigned PAR_W      = 2;
    localparam int unsigned TAIL_W     = 16;
    localparam int unsigned RANK_W     = 8;
    localparam int unsigned WORD_W     = 512;

    localparam int unsigned N      = SA_ROW_NUM * ROW_NUM;
    localparam int unsigned TSET_W = TAIL_W * PAR_W;
    localparam int unsigned RSET_W = RANK_W * PAR_W;
    localparam int unsigned RIDX_W = $clog2(ROW_NUM + 1);

    // One zero-extended scalar per entry, or PAR_W scalars packed per entry.
    localparam logic MODE_SCALAR = 1'b0;
    localparam logic MODE_PACKED = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_e;

endpackage

// File: rtl/e_scale_bank.sv
// Two-bank scale array with a streaming write port into one bank and a registered
// channel-parallel read port from the other.
//   clk, reset          : clock, synchronous active-high reset (clears both banks)
//   start_i             : rewind write pointer and open the stream
//   mode_i              : MODE_SCALAR / MODE_PACKED lane interpretation
//   wr_sel_i            : bank receiving stream writes (the shadow bank)
//   valid_i/ready_o     : stream handshake, word_i carries the lanes
//   done_o              : pointer has reached N
//   rd_sel_i, rd_idx_i  : bank and row (1..ROW_NUM, 0 = none) to read
//   sets_o              : one set per channel group, registered, 1-cycle latency
module e_scale_bank
    import e_scale_dbuf_loader_pkg::MODE_PACKED;
#(
    parameter  int unsigned SCAL_W  = 16,
    parameter  int unsigned PAR_W   = 2,
    parameter  int unsigned N       = 64,
    parameter  int unsigned ROW_NUM = 16,
    parameter  int unsigned WORD_W  = 512,
    localparam int unsigned SET_W   = SCAL_W * PAR_W,
    localparam int unsigned CH      = N / ROW_NUM,
    localparam int unsigned RIDX_W  = $clog2(ROW_NUM + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    mode_i,
    input  logic                    wr_sel_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [WORD_W-1:0]       word_i,
    output logic                    done_o,
    input  logic                    rd_sel_i,
    input  logic [RIDX_W-1:0]       rd_idx_i,
    output logic [CH*SET_W-1:0]     sets_o
);

    localparam int unsigned LANES0 = WORD_W / SCAL_W;
    localparam int unsigned LANES1 = WORD_W / SET_W;
    localparam int unsigned PTR_W  = $clog2(N + 1);
    localparam int unsigned AW     = $clog2(N);
    localparam int unsigned WI     = $clog2(N + LANES0 + 1);

    logic [SET_W-1:0]    mem_q [2][N];
    logic [PTR_W-1:0]    ptr_q;
    logic                ready_q;
    logic [CH*SET_W-1:0] sets_q;
    logic [CH*SET_W-1:0] sets_d;
    logic [SET_W-1:0]    lane_data [LANES0];
    logic [WI-1:0]       epw;
    logic [WI-1:0]       ptr_sum;
    logic                hs;

    // Lane k as an entry value: packed set in packed mode, zero-extended scalar otherwise.
    for (genvar k = 0; k < int'(LANES0); k++) begin : g_lane
        logic [SET_W-1:0] scal_ext;
        assign scal_ext = SET_W'(word_i[k*SCAL_W +: SCAL_W]);
        if (k < int'(LANES1)) begin : g_pk
            assign lane_data[k] = (mode_i == MODE_PACKED) ? word_i[k*SET_W +: SET_W] : scal_ext;
        end else begin : g_sc
            assign lane_data[k] = scal_ext;
        end
    end

    assign epw     = (mode_i == MODE_PACKED) ? WI'(LANES1) : WI'(LANES0);
    assign ptr_sum = WI'(ptr_q) + epw;
    assign hs      = valid_i & ready_q;

    // Stream write: lanes land at ptr..ptr+epw-1, clipped at the last entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < int'(N); e++) begin
                    mem_q[1'(b)][AW'(e)] <= '0;
                end
            end
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else if (start_i) begin
            ptr_q   <= '0;
            ready_q <= 1'b1;
        end else if (hs) begin
            for (int k = 0; k < int'(LANES0); k++) begin
                if ((WI'(k) < epw) && ((WI'(ptr_q) + WI'(k)) < WI'(N))) begin
                    mem_q[wr_sel_i][AW'(WI'(ptr_q) + WI'(k))] <= lane_data[k];
                end
            end
            if (ptr_sum >= WI'(N)) begin
                ptr_q   <= PTR_W'(N);
                ready_q <= 1'b0;
            end else begin
                ptr_q   <= PTR_W'(ptr_sum);
            end
        end
    end

    // Channel c reads entry c*ROW_NUM + rd_idx - 1; out-of-range rows read as zero.
    always_comb begin
        sets_d = '0;
        if ((rd_idx_i != '0) && (rd_idx_i <= RIDX_W'(ROW_NUM))) begin
            for (int c = 0; c < int'(CH); c++) begin
                sets_d[c*SET_W +: SET_W] =
                    mem_q[rd_sel_i][AW'(c * int'(ROW_NUM)) + AW'(rd_idx_i) - AW'(1)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sets_q <= '0;
        end else begin
            sets_q <= sets_d;
        end
    end

    assign ready_o = ready_q;
    assign done_o  = (ptr_q == PTR_W'(N));
    assign sets_o  = sets_q;

endmodule

// File: rtl/e_scale_dbuf_loader.sv
// Double-buffered E-scale register file (tail + rank) for the requant stage. Scale words
// stream into the shadow bank while the active bank feeds the output; a swap makes the
// freshly loaded scales live without stalling.
//   clk, reset                    : clock, synchronous active-high reset
//   load_start_i, load_mode_i     : begin a shadow load (ignored unless idle), lane mode
//   tail_valid_i/ready_o/word_i   : tail scale stream
//   rank_valid_i/ready_o/word_i   : rank scale stream
//   shadow_full_o                 : shadow bank complete, waiting for swap
//   swap_i, swap_ack_o            : shadow<->active exchange request and 1-cycle ack
//   rd_idx_i                      : output row 1..ROW_NUM (0 = none)
//   tail_sets_o, rank_sets_o      : active sets per channel group, 1-cycle read latency
module e_scale_dbuf_loader
    import e_scale_dbuf_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_start_i,
    input  logic                         load_mode_i,
    input  logic                         tail_valid_i,
    output logic                         tail_ready_o,
    input  logic [WORD_W-1:0]            tail_word_i,
    input  logic                         rank_valid_i,
    output logic                         rank_ready_o,
    input  logic [WORD_W-1:0]            rank_word_i,
    output logic                         shadow_full_o,
    input  logic                         swap_i,
    output logic                         swap_ack_o,
    input  logic [RIDX_W-1:0]            rd_idx_i,
    output logic [SA_ROW_NUM*TSET_W-1:0] tail_sets_o,
    output logic [SA_ROW_NUM*RSET_W-1:0] rank_sets_o
);

    state_e state_q;
    logic   sel_q;
    logic   mode_q;
    logic   full_q;
    logic   swap_ack_q;
    logic   start;
    logic   tail_done;
    logic   rank_done;

    assign start = (state_q == ST_IDLE) && load_start_i;

    // Loader FSM; the active bank only changes on an acknowledged swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            mode_q     <= MODE_SCALAR;
            full_q     <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            swap_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start_i) begin
                        state_q <= ST_LOAD;
                        mode_q  <= load_mode_i;
                    end
                end
                ST_LOAD: begin
                    if (tail_done && rank_done) begin
                        state_q <= ST_FULL;
                        full_q  <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (swap_i) begin
                        state_q    <= ST_IDLE;
                        full_q     <= 1'b0;
                        sel_q      <= ~sel_q;
                        swap_ack_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    full_q  <= 1'b0;
                end
            endcase
        end
    end

    e_scale_bank #(
        .SCAL_W  (TAIL_W),
        .PAR_W   (PAR_W),
        .N       (N),
        .ROW_NUM (ROW_NUM),
        .WORD_W  (WORD_W)
    ) u_tail_bank (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start),
        .mode_i   (mode_q),
        .wr_sel_i (~sel_q),
        .valid_i  (tail_valid_i),
        .ready_o  (tail_ready_o),
        .word_i   (tail_word_i),
        .done_o   (tail_done),
        .rd_sel_i (sel_q),
        .rd_idx_i (rd_idx_i),
        .sets_o   (tail_sets_o)
    );

    e_scale_bank #(
        .SCAL_W  (RANK_W),
        .PAR_W   (PAR_W),
        .N       (N),
        .ROW_NUM (ROW_NUM),
        .WORD_W  (WORD_W)
    ) u_rank_bank (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start),
        .mode_i   (mode_q),
        .wr_sel_i (~sel_q),
        .valid_i  (rank_valid_i),
        .ready_o  (rank_ready_o),
        .word_i   (rank_word_i),
        .done_o   (rank_done),
        .rd_sel_i (sel_q),
        .rd_idx_i (rd_idx_i),
        .sets_o   (rank_sets_o)
    );

    assign shadow_full_o = full_q;
    assign swap_ack_o    = swap_ack_q;

endmodule

// File: tb/tb_e_scale_dbuf_loader.sv
// Directed bench for e_scale_dbuf_loader: a bank model plus a read scoreboard.
module tb_e_scale_dbuf_loader;
    import e_scale_dbuf_loader_pkg::*;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         load_start_i, load_mode_i;
    logic                         tail_valid_i, tail_ready_o;
    logic [WORD_W-1:0]            tail_word_i;
    logic                         rank_valid_i, rank_ready_o;
    logic [WORD_W-1:0]            rank_word_i;
    logic                         shadow_full_o, swap_i, swap_ack_o;
    logic [RIDX_W-1:0]            rd_idx_i;
    logic [SA_ROW_NUM*TSET_W-1:0] tail_sets_o;
    logic [SA_ROW_NUM*RSET_W-1:0] rank_sets_o;

    e_scale_dbuf_loader dut (
        .clk(clk), .reset(reset),
        .load_start_i(load_start_i), .load_mode_i(load_mode_i),
        .tail_valid_i(tail_valid_i), .tail_ready_o(tail_ready_o), .tail_word_i(tail_word_i),
        .rank_valid_i(rank_valid_i), .rank_ready_o(rank_ready_o), .rank_word_i(rank_word_i),
        .shadow_full_o(shadow_full_o), .swap_i(swap_i), .swap_ack_o(swap_ack_o),
        .rd_idx_i(rd_idx_i), .tail_sets_o(tail_sets_o), .rank_sets_o(rank_sets_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SA_ROW_NUM*TSET_W-1:0] t;
        logic [SA_ROW_NUM*RSET_W-1:0] r;
    } rd_t;

    rd_t               exp_q[$];
    logic [TSET_W-1:0] m_tail [2][N];
    logic [RSET_W-1:0] m_rank [2][N];
    logic [TSET_W-1:0] dt [N];
    logic [RSET_W-1:0] dr [N];
    logic [WORD_W-1:0] tail_words [4];
    logic [WORD_W-1:0] rank_words [2];
    int                tw_n, rw_n;
    bit                msel;
    int                total  = 0;
    int                passed = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic rd_t model_read(input int idx, input bit s);
        rd_t x;
        x = '0;
        if (idx >= 1 && idx <= int'(ROW_NUM)) begin
            for (int c = 0; c < int'(SA_ROW_NUM); c++) begin
                x.t[c*TSET_W +: TSET_W] = m_tail[s][c*ROW_NUM + idx - 1];
                x.r[c*RSET_W +: RSET_W] = m_rank[s][c*ROW_NUM + idx - 1];
            end
        end
        return x;
    endfunction

    // One clock: expected read pushed before the edge, popped and compared after it.
    task automatic cycle();
        rd_t e;
        if (reset) e = '0;
        else       e = model_read(int'(rd_idx_i), msel);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("tail_sets", tail_sets_o, e.t);
        chk("rank_sets", rank_sets_o, e.r);
    endtask

    task automatic clear_model();
        for (int b = 0; b < 2; b++)
            for (int e = 0; e < int'(N); e++) begin
                m_tail[b][e] = '0;
                m_rank[b][e] = '0;
            end
        msel = 1'b0;
    endtask

    // Pack desired entry values dt/dr into stream words for the given mode.
    task automatic build_words(input logic mode);
        int te, re;
        te = mode ? int'(WORD_W / TSET_W) : int'(WORD_W / TAIL_W);
        re = mode ? int'(WORD_W / RSET_W) : int'(WORD_W / RANK_W);
        tw_n = (int'(N) + te - 1) / te;
        rw_n = (int'(N) + re - 1) / re;
        for (int w = 0; w < 4; w++) tail_words[w] = '0;
        for (int w = 0; w < 2; w++) rank_words[w] = '0;
        for (int e = 0; e < int'(N); e++) begin
            if (mode) begin
                tail_words[e/te][(e%te)*TSET_W +: TSET_W] = dt[e];
                rank_words[e/re][(e%re)*RSET_W +: RSET_W] = dr[e];
            end else begin
                tail_words[e/te][(e%te)*TAIL_W +: TAIL_W] = dt[e][TAIL_W-1:0];
                rank_words[e/re][(e%re)*RANK_W +: RANK_W] = dr[e][RANK_W-1:0];
            end
        end
    endtask

    // Full shadow load while sweeping reads over the active bank (rows 0..ROW_NUM+1).
    task automatic do_load(input logic mode, input bit toggle, input bit pokes);
        int tc, rc, age;
        bit t_hs, r_hs;
        build_words(mode);
        load_start_i = 1'b1;
        load_mode_i  = mode;
        cycle();
        load_start_i = 1'b0;
        load_mode_i  = ~mode;
        tc = 0; rc = 0; age = 0;
        for (int i = 0; i < 200 && age < 3; i++) begin
            tail_valid_i = toggle ? (i % 2 == 0) : 1'b1;
            rank_valid_i = toggle ? (i % 2 == 0) : 1'b1;
            tail_word_i  = tail_words[(tc < tw_n) ? tc : 0];
            rank_word_i  = rank_words[(rc < rw_n) ? rc : 0];
            rd_idx_i     = RIDX_W'(i % int'(ROW_NUM + 2));
            load_start_i = pokes && (i == 3);
            swap_i       = pokes && (i == 2);
            chk("tail_ready", tail_ready_o, tc < tw_n);
            chk("rank_ready", rank_ready_o, rc < rw_n);
            if (age == 0 || age >= 2) chk("shadow_full", shadow_full_o, age >= 2);
            t_hs = tail_valid_i && tail_ready_o;
            r_hs = rank_valid_i && rank_ready_o;
            cycle();
            if (t_hs) tc++;
            if (r_hs) rc++;
            chk("swap_ack_idle", swap_ack_o, 1'b0);
            if (age > 0 || (tc == tw_n && rc == rw_n)) age++;
        end
        chk("load_complete", age >= 3, 1'b1);
        tail_valid_i = 1'b0; rank_valid_i = 1'b0;
        load_start_i = 1'b0; swap_i = 1'b0;
        for (int e = 0; e < int'(N); e++) begin
            m_tail[!msel][e] = mode ? dt[e] : TSET_W'(dt[e][TAIL_W-1:0]);
            m_rank[!msel][e] = mode ? dr[e] : RSET_W'(dr[e][RANK_W-1:0]);
        end
    endtask

    // Swap with rd_idx held: the swap-edge read is old data, the next read is new.
    task automatic do_swap(input int idx);
        rd_idx_i = RIDX_W'(idx);
        swap_i   = 1'b1;
        cycle();
        swap_i = 1'b0;
        msel   = ~msel;
        chk("swap_ack", swap_ack_o, 1'b1);
        chk("full_after_swap", shadow_full_o, 1'b0);
        cycle();
        chk("swap_ack_pulse", swap_ack_o, 1'b0);
    endtask

    initial begin
        reset = 1'b1; load_start_i = 1'b0; load_mode_i = 1'b0;
        tail_valid_i = 1'b0; rank_valid_i = 1'b0; tail_word_i = '0; rank_word_i = '0;
        swap_i = 1'b0; rd_idx_i = RIDX_W'(1);
        clear_model();

        // Reset held three cycles
        repeat (3) cycle();
        reset = 1'b0;
        chk("rst_tail_ready", tail_ready_o, 1'b0);
        chk("rst_rank_ready", rank_ready_o, 1'b0);
        chk("rst_shadow_full", shadow_full_o, 1'b0);
        chk("rst_swap_ack", swap_ack_o, 1'b0);
        cycle();

        // Scalar mode: junk in the upper set bits of the source values must not appear
        for (int e = 0; e < int'(N); e++) begin
            dt[e] = {16'hDEAD, 16'(e + 1)};
            dr[e] = {8'hBE, 8'(e + 1)};
        end
        do_load(MODE_SCALAR, 1'b0, 1'b0);
        do_swap(1);
        chk("m0_tail_lit", tail_sets_o, {32'h31, 32'h21, 32'h11, 32'h01});
        chk("m0_rank_lit", rank_sets_o, {16'h31, 16'h21, 16'h11, 16'h01});

        // Packed mode, toggling valids, reads sweeping the live bank, stray start/swap
        for (int e = 0; e < int'(N); e++) begin
            dt[e] = {16'(e + 16'h100), 16'(e * 7)};
            dr[e] = {8'(e ^ 8'h5A), 8'(e + 3)};
        end
        do_load(MODE_PACKED, 1'b1, 1'b1);
        do_swap(2);

        // Reset during a load aborts it and clears both banks
        for (int e = 0; e < int'(N); e++) begin
            dt[e] = 32'hC0DE0000 | 32'(e);
            dr[e] = 16'hF000 | 16'(e);
        end
        build_words(MODE_SCALAR);
        load_start_i = 1'b1; load_mode_i = MODE_SCALAR;
        cycle();
        load_start_i = 1'b0;
        tail_valid_i = 1'b1; tail_word_i = tail_words[0];
        chk("abort_ready", tail_ready_o, 1'b1);
        cycle();
        tail_valid_i = 1'b0;
        swap_i = 1'b1;
        cycle();
        swap_i = 1'b0;
        chk("swap_in_load_ack", swap_ack_o, 1'b0);
        reset = 1'b1;
        clear_model();
        repeat (2) cycle();
        reset = 1'b0;
        chk("abort_tail_ready", tail_ready_o, 1'b0);
        chk("abort_shadow_full", shadow_full_o, 1'b0);
        rd_idx_i = RIDX_W'(1);
        cycle();
        do_load(MODE_PACKED, 1'b0, 1'b0);
        do_swap(3);
        chk("fresh_tail_lit", tail_sets_o[TSET_W-1:0], 32'hC0DE0002);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
